// File: rtl/de0_cv_qsys_pio_in_capture.sv
// Avalon-MM input PIO with synchroniser, per-bit edge capture and masked level interrupt.
// Build option: define PIO_IN_CAPTURE_BITCLR_EN for write-1-to-clear EDGECAP (otherwise any write clears all).
module de0_cv_qsys_pio_in_capture #(
  parameter int WIDTH       = 9,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int SETTLE = SYNC_STAGES + 1;
  localparam int CNT_W  = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

  logic [WIDTH-1:0] sync_p0 [SYNC_STAGES];
  logic [WIDTH-1:0] prev_p1;
  logic [WIDTH-1:0] sync_cur;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] edgecap_next;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] irqmask_next;
  logic [31:0]      rd_sel;
  logic [CNT_W-1:0] settle_cnt;
  logic             settled;
  logic             wr_mask;
  logic             wr_cap;
  logic             unused_wdata;

  function automatic logic [WIDTH-1:0] edge_detect(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] prv);
    case (EDGE_TYPE)
      0:       return cur & ~prv;
      1:       return ~cur & prv;
      default: return cur ^ prv;
    endcase
  endfunction

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  assign unused_wdata = ^writedata;

  always_comb begin
    sync_cur = sync_p0[SYNC_STAGES-1];
    settled  = (settle_cnt == SETTLE_CNT);
    // Flops loading out of reset look like edges until the whole chain has filled.
    det      = edge_detect(sync_cur, prev_p1) & {WIDTH{settled}};
    wr_mask  = chipselect & ~write_n & (address == 2'd2);
    wr_cap   = chipselect & ~write_n & (address == 2'd3);
`ifdef PIO_IN_CAPTURE_BITCLR_EN
    clr = wr_cap ? writedata[WIDTH-1:0] : '0;
`else
    clr = {WIDTH{wr_cap}};
`endif
    // A fresh edge beats a clear landing on the same bit in the same cycle.
    edgecap_next = (edgecap & ~clr) | det;
    irqmask_next = wr_mask ? writedata[WIDTH-1:0] : irqmask;
    case (address)
      2'd0:    rd_sel = zext(sync_cur);
      2'd2:    rd_sel = zext(irqmask);
      2'd3:    rd_sel = zext(edgecap);
      default: rd_sel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p0[i] <= '0;
      prev_p1    <= '0;
      settle_cnt <= '0;
      edgecap    <= '0;
      irqmask    <= '0;
      readdata   <= '0;
      irq        <= 1'b0;
    end else begin
      sync_p0[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p0[i] <= sync_p0[i-1];
      prev_p1 <= sync_cur;
      if (!settled) settle_cnt <= settle_cnt + CNT_W'(1);
      edgecap <= edgecap_next;
      irqmask <= irqmask_next;
      irq     <= |(edgecap_next & irqmask_next);
      if (chipselect && write_n) readdata <= rd_sel;
    end
  end

endmodule
